// File: rtl/systolic_cluster_sequencer.sv
// Command sequencer for a cluster of systolic arrays: steps each command through
// CLEAR, LOAD, COMPUTE, DRAIN and DONE and drives the cluster control strobes.
module systolic_cluster_sequencer #(
  parameter int NUM_ARRAYS   = 8,
  parameter int K_BITS       = 8,
  parameter int DRAIN_CYCLES = 2,
  localparam int SEL_BITS    = (NUM_ARRAYS > 1) ? $clog2(NUM_ARRAYS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [SEL_BITS-1:0] cmd_array,
  input  logic                cmd_broadcast,
  input  logic                cmd_skip_load,
  input  logic [K_BITS-1:0]   cmd_k,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic                abort,
  output logic                ctl_enable,
  output logic [SEL_BITS-1:0] ctl_array_select,
  output logic                ctl_clear_acc,
  output logic                ctl_load_weights,
  output logic                ctl_compute_enable,
  output logic                ctl_broadcast_mode,
  output logic                busy,
  output logic                done,
  output logic                aborted
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    LOAD    = 3'd2,
    COMPUTE = 3'd3,
    DRAIN   = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  state_t              state, state_nx;
  logic [K_BITS-1:0]   beat_cnt;
  logic [K_BITS-1:0]   k_q;
  logic [K_BITS-1:0]   k_last;
  logic [3:0]          drain_cnt;
  logic [SEL_BITS-1:0] sel_q;
  logic                bcast_q;
  logic                skip_q;
  logic                aborted_q;
  logic                active;
  logic                kill;

  assign k_last = k_q - 1'b1;
  assign active = (state != IDLE);
  assign kill   = active && abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      k_q       <= '0;
      sel_q     <= '0;
      bcast_q   <= 1'b0;
      skip_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state     <= state_nx;
      aborted_q <= kill;
      if (state == IDLE && cmd_valid) begin
        k_q      <= cmd_k;
        sel_q    <= cmd_array;
        bcast_q  <= cmd_broadcast;
        skip_q   <= cmd_skip_load;
        beat_cnt <= '0;
      end else if (ctl_compute_enable) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (state == DRAIN && state_nx == DRAIN)
        drain_cnt <= drain_cnt + 1'b1;
      else
        drain_cnt <= '0;
    end
  end

  always_comb begin
    state_nx           = state;
    cmd_ready          = 1'b0;
    op_ready           = 1'b0;
    ctl_enable         = 1'b0;
    ctl_clear_acc      = 1'b0;
    ctl_load_weights   = 1'b0;
    ctl_compute_enable = 1'b0;
    done               = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nx = CLEAR;
      end
      CLEAR: begin
        ctl_enable    = 1'b1;
        ctl_clear_acc = 1'b1;
        if (k_q == '0)  state_nx = DONE;
        else if (skip_q) state_nx = COMPUTE;
        else             state_nx = LOAD;
      end
      LOAD: begin
        op_ready = 1'b1;
        if (op_valid) begin
          ctl_enable       = 1'b1;
          ctl_load_weights = 1'b1;
          state_nx         = COMPUTE;
        end
      end
      COMPUTE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          ctl_enable         = 1'b1;
          ctl_compute_enable = 1'b1;
          if (beat_cnt == k_last) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // Abort cancels everything visible this cycle, including completion in DONE.
    if (kill) begin
      state_nx           = IDLE;
      op_ready           = 1'b0;
      ctl_enable         = 1'b0;
      ctl_clear_acc      = 1'b0;
      ctl_load_weights   = 1'b0;
      ctl_compute_enable = 1'b0;
      done               = 1'b0;
    end

    if (reset) begin
      cmd_ready          = 1'b0;
      op_ready           = 1'b0;
      ctl_enable         = 1'b0;
      ctl_clear_acc      = 1'b0;
      ctl_load_weights   = 1'b0;
      ctl_compute_enable = 1'b0;
      done               = 1'b0;
    end
  end

  assign busy               = active && !reset;
  assign aborted            = aborted_q && !reset;
  assign ctl_array_select   = reset ? '0 : sel_q;
  assign ctl_broadcast_mode = bcast_q && !reset;

endmodule
